// File: rtl/pwm_servo_pkg.sv
// pwm_servo_pkg: default constants and channel-index width helper for the servo PWM bank
package pwm_servo_pkg;
  localparam int N_CH_DEF = 6;
  localparam int CNT_W_DEF = 21;
  localparam int PERIOD_DEF = 2000000;
  localparam int DUTY_MIN_DEF = 100000;
  localparam int DUTY_MAX_DEF = 200000;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_servo_chan.sv
// pwm_servo_chan: one channel's duty shadow, active duty and registered comparator
module pwm_servo_chan
  import pwm_servo_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr,
  input  logic             load,
  input  logic             cmp_en,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);
  logic [CNT_W-1:0] duty_sh, duty_act;
  // shadow takes writes; active copies the pre-write shadow on load; output compares against the current active duty
  always_ff @(posedge clk)
    if (res) begin
      duty_sh <= '0;
      duty_act <= '0;
      pwm <= 1'b0;
    end else begin
      if (wr) duty_sh <= wr_duty;
      if (load) duty_act <= duty_sh;
      pwm <= cmp_en & (cnt < duty_act);
    end
endmodule

// File: rtl/pwm_servo_bank.sv
// pwm_servo_bank: shared-counter servo PWM bank with shadowed duty/period; define SERVO_CLAMP_EN to clamp written duties
module pwm_servo_bank
  import pwm_servo_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PERIOD_RST = PERIOD_DEF,
  parameter int DUTY_MIN = DUTY_MIN_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    enable,
  input  logic                    wr_en,
  input  logic [ch_w(N_CH)-1:0]   wr_ch,
  input  logic [CNT_W-1:0]        wr_duty,
  input  logic                    per_wr,
  input  logic [CNT_W-1:0]        per_val,
  output logic [N_CH-1:0]         pwm,
  output logic                    frame
);
  localparam int CH_W = ch_w(N_CH);
  logic [CNT_W-1:0] cnt, per_sh, per_act, wr_val;
  logic run, idle_per, start, cmp_en, wrap, load;
  if (DUTY_MIN > DUTY_MAX) begin : g_bad_clamp
    $error("DUTY_MIN exceeds DUTY_MAX");
  end
  // a period below 2 parks the bank; loads happen on start, on wrap, and continuously while parked so a new period is picked up
  always_comb begin
    idle_per = per_act < CNT_W'(2);
    start = enable & ~run;
    cmp_en = enable & run & ~idle_per;
    wrap = cmp_en & (cnt == per_act - 1'b1);
    load = start | wrap | (enable & idle_per);
  end
`ifdef SERVO_CLAMP_EN
  // clamp written duty into the servo range, keeping 0 as channel-off
  always_comb
    wr_val = wr_duty == '0 ? '0 :
             wr_duty < CNT_W'(DUTY_MIN) ? CNT_W'(DUTY_MIN) :
             wr_duty > CNT_W'(DUTY_MAX) ? CNT_W'(DUTY_MAX) : wr_duty;
`else
  // written duty is stored as given
  always_comb wr_val = wr_duty;
`endif
  // shared counter, period shadow/active and frame pulse marking the first cycle of each loaded period
  always_ff @(posedge clk)
    if (res) begin
      cnt <= '0;
      per_sh <= CNT_W'(PERIOD_RST);
      per_act <= CNT_W'(PERIOD_RST);
      run <= 1'b0;
      frame <= 1'b0;
    end else begin
      run <= enable;
      if (per_wr) per_sh <= per_val;
      if (load) per_act <= per_sh;
      cnt <= (enable & ~load) ? cnt + 1'b1 : '0;
      frame <= load & (per_sh >= CNT_W'(2));
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_servo_chan #(.CNT_W(CNT_W)) u_chan (
      .clk(clk),
      .res(res),
      .wr(wr_en & (wr_ch == CH_W'(i))),
      .load(load),
      .cmp_en(cmp_en),
      .wr_duty(wr_val),
      .cnt(cnt),
      .pwm(pwm[i])
    );
  end
endmodule

// File: tb/tb_pwm_servo_bank.sv
// tb_pwm_servo_bank: scoreboard bench measuring per-period high times of a scaled servo bank
module tb_pwm_servo_bank;
  typedef struct packed {
    logic [15:0] len;
    logic [5:0][7:0] hi;
  } rec_t;
  logic clk, res, enable, wr_en, per_wr, frame;
  logic [2:0] wr_ch;
  logic [20:0] wr_duty, per_val;
  logic [5:0] pwm;
  rec_t q[$];
  rec_t acc;
  logic fprev, open;
  int tb_pass = 0, tb_total = 0, mon_pass = 0, mon_total = 0;

  pwm_servo_bank #(.N_CH(6), .CNT_W(21), .PERIOD_RST(20), .DUTY_MIN(3), .DUTY_MAX(16)) dut (
    .clk(clk), .res(res), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .per_wr(per_wr), .per_val(per_val), .pwm(pwm), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input int len, input int h0, input int h1, input int h2,
                              input int h3, input int h4, input int h5);
    rec_t r;
    r.len = 16'(len);
    r.hi[0] = 8'(h0); r.hi[1] = 8'(h1); r.hi[2] = 8'(h2);
    r.hi[3] = 8'(h3); r.hi[4] = 8'(h4); r.hi[5] = 8'(h5);
    return r;
  endfunction

  // monitor: a window spans the pwm cycles of one period (starting the cycle after frame)
  always @(negedge clk) begin
    if (res || !enable) begin
      open = 1'b0;
      fprev = 1'b0;
      acc = '0;
    end else begin
      if (fprev) begin
        if (open) begin
          mon_total++;
          if (q.size() == 0) begin
            $display("FAIL window unexpected got %h want none", acc);
          end else begin
            rec_t e;
            e = q.pop_front();
            if (acc === e) mon_pass++;
            else $display("FAIL window len/hi got %h want %h", acc, e);
          end
        end
        open = 1'b1;
        acc = '0;
      end
      acc.len = acc.len + 16'd1;
      for (int c = 0; c < 6; c++) if (pwm[c]) acc.hi[c] = acc.hi[c] + 8'd1;
      fprev = frame;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tb_total++;
    if (act == exp) tb_pass++;
    else $display("FAIL %s got %0d want %0d", nm, act, exp);
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_duty = 21'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic per(input int p);
    per_wr = 1'b1; per_val = 21'(p);
    tick();
    per_wr = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      tb_total++;
      $display("FAIL %s drain got %0d pending want 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic wait_frame(input string nm);
    int seen;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (frame) seen = 1;
    end
    if (seen == 0) begin
      tb_total++;
      $display("FAIL %s frame got none want pulse", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int bad;
    res = 1'b1; enable = 1'b0; wr_en = 1'b0; per_wr = 1'b0;
    wr_ch = '0; wr_duty = '0; per_val = '0;
    repeat (3) tick();
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_frame", int'(frame), 0);
    res = 1'b0;
    tick();
    // first period runs with pre-write shadows, new duty from the next frame
    enable = 1'b1;
    q.push_back(mk(20, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(20, 15, 0, 0, 0, 0, 0));
    q.push_back(mk(20, 15, 0, 0, 0, 0, 0));
    wr(0, 15);
    drain("first_period");
    enable = 1'b0;
    tick();
    // period 10 with simultaneous period/duty write, out-of-range channels ignored
    wr_en = 1'b1; wr_ch = 3'd0; wr_duty = 21'd0; per_wr = 1'b1; per_val = 21'd10;
    tick();
    wr_en = 1'b0; per_wr = 1'b0;
    wr(1, 5); wr(2, 10); wr(3, 15); wr(6, 7); wr(7, 9);
    enable = 1'b1;
    q.push_back(mk(10, 0, 5, 10, 10, 0, 0));
    q.push_back(mk(10, 0, 5, 10, 10, 0, 0));
    drain("per10");
    enable = 1'b0;
    tick();
    // write landing in the wrap cycle takes effect one period later
    enable = 1'b1;
    q.push_back(mk(10, 0, 5, 10, 10, 0, 0));
    q.push_back(mk(10, 0, 5, 10, 10, 0, 0));
    q.push_back(mk(10, 0, 5, 3, 10, 0, 0));
    q.push_back(mk(10, 0, 5, 3, 10, 0, 0));
    wait_frame("wrap_write");
    repeat (9) @(posedge clk);
    #1;
    wr(2, 3);
    drain("wrap_write");
    enable = 1'b0;
    tick();
    // enable dropped mid-period, then a fresh period with the current shadows
    enable = 1'b1;
    wait_frame("drop");
    repeat (3) @(posedge clk);
    #1;
    chk("running_pwm3", int'(pwm[3]), 1);
    enable = 1'b0;
    tick();
    chk("drop_pwm", int'(pwm), 0);
    chk("drop_frame", int'(frame), 0);
    wr(1, 7);
    enable = 1'b1;
    q.push_back(mk(10, 0, 7, 3, 10, 0, 0));
    drain("reenable");
    enable = 1'b0;
    tick();
    // period below 2 parks the bank until a valid period is written
    per(1);
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (frame || pwm != 6'd0) bad++;
    end
    chk("short_period_idle", bad, 0);
    q.push_back(mk(10, 0, 7, 3, 10, 0, 0));
    per(10);
    drain("short_period_recover");
    enable = 1'b0;
    tick();
    // clamp bounds (stored verbatim without the clamp feature)
    per(24);
    wr(0, 1); wr(1, 30); wr(2, 0); wr(3, 16); wr(4, 3);
    enable = 1'b1;
`ifdef SERVO_CLAMP_EN
    q.push_back(mk(24, 3, 16, 0, 16, 3, 0));
`else
    q.push_back(mk(24, 1, 24, 0, 16, 3, 0));
`endif
    drain("clamp");
    enable = 1'b0;
    tick();
    // reset mid-period discards a concurrent write and restores defaults
    enable = 1'b1;
    wait_frame("midreset");
    repeat (5) @(posedge clk);
    #1;
    res = 1'b1;
    wr(0, 9);
    chk("midreset_pwm", int'(pwm), 0);
    chk("midreset_frame", int'(frame), 0);
    tick();
    q.push_back(mk(20, 0, 0, 0, 0, 0, 0));
    res = 1'b0;
    drain("after_reset");
    enable = 1'b0;
    tick();
    $display("%0d/%0d checks passed", tb_pass + mon_pass, tb_total + mon_total);
    $finish;
  end
endmodule

// File: doc/pwm_servo_bank.md
PWM_SERVO_BANK -- requirements
Module: pwm_servo_bank

Interface
REQ-001 Parameter N_CH, default 6: number of independent servo PWM channels (1..16).
REQ-002 Parameter CNT_W, default 21: width of the period counter, duty registers and period register.
REQ-003 Parameter PERIOD_RST, default 2000000: period in clk cycles after reset (20 ms at 100 MHz).
REQ-004 Parameter DUTY_MIN, default 100000 (1 ms): lower clamp bound, used only with SERVO_CLAMP_EN.
REQ-005 Parameter DUTY_MAX, default 200000 (2 ms): upper clamp bound, used only with SERVO_CLAMP_EN.
REQ-006 clk  in  1  single clock for the block; every register samples on its rising edge.
REQ-007 res  in  1  reset, synchronous and active-high.
REQ-008 enable  in  1  run control; when low, the counter and outputs are held idle.
REQ-009 wr_en  in  1  single-cycle strobe that writes wr_duty into the shadow duty register of wr_ch.
REQ-010 wr_ch  in  $clog2(N_CH) (min 1)  channel index for the write.
REQ-011 wr_duty  in  CNT_W  requested high time in clk cycles.
REQ-012 per_wr  in  1  single-cycle strobe that writes per_val into the shadow period register.
REQ-013 per_val  in  CNT_W  requested period in clk cycles.
REQ-014 pwm  out  N_CH  registered PWM outputs, one bit per channel.
REQ-015 frame  out  1  one-cycle pulse in the cycle the counter wraps to 0.

Function
REQ-016 The block SHALL use one shared counter, cnt, that runs 0..per_act-1 and then wraps to 0 while enable=1.
REQ-017 Each channel i SHALL drive pwm[i] <= enable & (cnt < duty_act[i]), registered, one cycle after cnt.
REQ-018 When cnt==per_act-1, the next cycle SHALL load duty_act[all] from the duty shadows and per_act from the period shadow, and SHALL assert frame.
REQ-019 A write that lands in the wrap cycle SHALL update only the shadow; the active register loads the pre-write shadow value, and the new value takes effect one period later.
REQ-020 If wr_ch >= N_CH, the write SHALL be ignored.
REQ-021 duty_act = 0 SHALL hold the output constantly low; duty_act >= per_act SHALL hold it constantly high for the whole period.
REQ-022 per_act < 2 SHALL hold cnt at 0, pwm at all-zero and frame low.
REQ-023 When enable=0, cnt SHALL be 0, pwm all-zero and frame low, and the shadows SHALL stay writable.
REQ-024 On the first cycle with enable=1, the active registers SHALL load from the shadows before the first comparison.
REQ-025 Simultaneous wr_en and per_wr SHALL both take effect.

Reset
REQ-026 res=1 SHALL set cnt=0, pwm=0, frame=0, all duty shadow and active registers to 0, and per_shadow = per_act = PERIOD_RST.
REQ-027 res SHALL take priority over enable and all writes, including when it is asserted mid-period.

Configuration
REQ-028 With SERVO_CLAMP_EN defined, wr_duty SHALL be clamped to [DUTY_MIN, DUTY_MAX] before it is stored; a value of 0 is stored as 0, so the channel can be switched off.
REQ-029 Without SERVO_CLAMP_EN, wr_duty SHALL be stored unmodified, and DUTY_MIN and DUTY_MAX are unused.

Structure
REQ-030 The package pwm_servo_pkg SHALL hold the default constants (period, duty min/max, channel count) and the channel-index width function.
REQ-031 The per-channel shadow, active register and comparator SHALL be a sub-module, pwm_servo_chan, instantiated N_CH times with a generate loop.

Verification
REQ-032 Reset, enable=1, ch0 duty=150000 -> pwm[0] stays low during the first period; from the second frame pulse, pwm[0] is high for exactly 150000 cycles of each 2000000-cycle period.
REQ-033 Write ch2 duty in the wrap cycle (cnt=per_act-1) -> the old duty is used for one more period and the new duty applies in the following period.
REQ-034 per_val=10, duty=0/5/10/15 on ch0..3 -> outputs low / 5-of-10 high / always high / always high; frame fires every 10 cycles.
REQ-035 enable dropped mid-period -> pwm=0 and cnt=0 on the next cycle; on re-enable, the output starts a fresh period with the current shadows.
REQ-036 SERVO_CLAMP_EN build: write 50000 -> 100000 stored; write 300000 -> 200000 stored; write 0 -> 0 stored. Non-clamp build: values stored verbatim.
REQ-037 res asserted mid-period with wr_en=1 -> the write is discarded and all outputs and registers hold their reset values.
